ram_wb: RTL and testbench
=========================

# ram_wb

Write-back stage for the cpu15 data memory: holds the eight 16-bit data RAM words and the output port register, and drives them as parallel outputs into the read decoder. It accepts one write per cycle from the execute stage through a ready/valid handshake. It also runs an 8-cycle clear sequencer on request that zeroes the RAM words.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 8, RAM address width
- IO_OUT_ADDR, 8'h40, address of the output port register (IO64_OUT)

- CLK_WB  input  1  clock, all state on posedge
- RST  input  1  reset, synchronous and active-high
- RAM_AD_IN  input  ADDR_W  write address
- RAM_DATA_IN  input  DATA_W  write data
- RAM_WEN  input  1  write valid; held with address/data until accepted
- CLR_REQ  input  1  request to clear RAM words 0..7
- RAM_RDY  output  1  registered; write accepted on an edge where RAM_WEN && RAM_RDY
- WR_ERR  output  1  one-cycle pulse: accepted write hit an unmapped address
- RAM_0 … RAM_7  output  DATA_W each  stored RAM words, addresses 8'h00–8'h07
- IO64_OUT  output  DATA_W  output port register, address IO_OUT_ADDR

## Operation
- States: IDLE, CLEAR. RAM_RDY = (state == IDLE), registered.
- Accepted write, RAM_WEN && RAM_RDY:
  - address 8'h00–8'h07: RAM_n <= RAM_DATA_IN.
  - address IO_OUT_ADDR: IO64_OUT <= RAM_DATA_IN.
  - any other address, including 8'h41, which is input-only: no storage change; WR_ERR = 1 next cycle.
- RAM_WEN while RAM_RDY = 0: not accepted, no effect. Requester keeps holding the write.
- IDLE → CLEAR on CLR_REQ = 1. Clear index cnt (3 bits) <= 0.
- CLEAR:
  - Each cycle RAM_[cnt] <= 0 and cnt <= cnt + 1.
  - After clearing word 7, state → IDLE.
  - IO64_OUT is never cleared by the sequencer.
  - CLR_REQ is ignored while in CLEAR.
- CLR_REQ and an accepted write on the same IDLE edge:
  - The write commits at that edge, and WR_ERR is raised if the address is unmapped.
  - The clear starts next cycle and overwrites any RAM word just written. This is intended; software must not rely on the write surviving.
- Writes never wrap or truncate. Address is compared on all ADDR_W bits.

## Timing
- Reset, at the RST edge:
  - RAM_0..RAM_7 = 0, IO64_OUT = 0.
  - WR_ERR = 0, RAM_RDY = 1, state = IDLE, cnt = 0.
- RST asserted during CLEAR aborts the clear and applies the reset values. RST has priority over every other input.
- Write latency: data is visible on RAM_n / IO64_OUT in the cycle after the accepting edge.
- WR_ERR is asserted in the cycle after the accepting edge, for exactly one cycle.
- Clear timing, with CLR_REQ sampled at edge E0:
  - RAM_RDY = 0 for cycles after E0 through E8.
  - Word k reads 0 from the cycle after edge E(k+1).
  - RAM_RDY = 1 again after E8.
  - Total: 8 unavailable cycles.
- Back-to-back writes at one per cycle are sustained in IDLE.
- No combinational path from any input to any output.

## Structure
- Shared package cpu15_pkg holds:
  - RAM_WORDS = 8
  - IO64_ADDR = 8'h40 and IO65_ADDR = 8'h41, also used by the read decoder
  - state enum {IDLE, CLEAR}
- Storage is a flat 8×DATA_W register array mapped onto the RAM_n ports.
- No sub-module: the clear sequencer and the write decode are small enough to live in ram_wb.

## Test plan
- Reset then idle → all RAM_n = 16'h0000, IO64_OUT = 0, RAM_RDY = 1, WR_ERR = 0.
- Write 8'h03 ← 16'hBEEF, then 8'h40 ← 16'h1234 on consecutive cycles:
  - RAM_3 = BEEF one cycle after the first edge.
  - IO64_OUT = 1234 one cycle after the second edge.
  - Other words remain 0.
- Write 8'h41 ← 16'hFFFF and 8'h08 ← 16'h0001 → WR_ERR pulses one cycle each; no output changes.
- Fill words 0..7 with 16'h00A0+n, set IO64_OUT = 16'h5555, pulse CLR_REQ:
  - RAM_RDY low for exactly 8 cycles.
  - Word k reaches 0 on cycle k+1.
  - IO64_OUT stays 5555.
- During CLEAR, hold RAM_WEN with 8'h02 ← 16'h7777:
  - Not accepted until RAM_RDY returns.
  - Then accepted once, and RAM_2 = 7777 after the clear ends.
- Assert RST at clear cycle 4 → all words 0, state IDLE, RAM_RDY = 1 the next cycle. A same-cycle CLR_REQ + write to 8'h05 ← 16'h1111 leaves RAM_5 = 0 after the clear.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared cpu15 constants and types for the data memory write-back stage
// and the read decoder.
package cpu15_pkg;

   localparam int         RAM_WORDS = 8;
   localparam int         CNT_W     = $clog2(RAM_WORDS);
   localparam logic [7:0] IO64_ADDR = 8'h40;
   localparam logic [7:0] IO65_ADDR = 8'h41;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } wb_state_e;

endpackage

// File: rtl/ram_wb.sv
// cpu15 write-back stage: eight data RAM words plus the output port register,
// one handshaked write per cycle, and an 8-cycle clear sequencer.
module ram_wb
   import cpu15_pkg::*;
#(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] IO_OUT_ADDR = ADDR_W'(IO64_ADDR)
) (
   input  logic              CLK_WB,
   input  logic              RST,
   input  logic [ADDR_W-1:0] RAM_AD_IN,
   input  logic [DATA_W-1:0] RAM_DATA_IN,
   input  logic              RAM_WEN,
   input  logic              CLR_REQ,
   output logic              RAM_RDY,
   output logic              WR_ERR,
   output logic [DATA_W-1:0] RAM_0,
   output logic [DATA_W-1:0] RAM_1,
   output logic [DATA_W-1:0] RAM_2,
   output logic [DATA_W-1:0] RAM_3,
   output logic [DATA_W-1:0] RAM_4,
   output logic [DATA_W-1:0] RAM_5,
   output logic [DATA_W-1:0] RAM_6,
   output logic [DATA_W-1:0] RAM_7,
   output logic [DATA_W-1:0] IO64_OUT
);

   wb_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mem_q [RAM_WORDS];
   logic [DATA_W-1:0] io_q;
   logic              rdy_q;
   logic              err_q;

   logic              accept;
   logic              hit_ram;
   logic              hit_io;

   // State register.
   always_ff @(posedge CLK_WB) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; CLR_REQ only matters in IDLE.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (CLR_REQ) state_d = CLEAR;
         CLEAR:   if (cnt_q == CNT_W'(RAM_WORDS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write decode; the address is compared on every bit, so nothing aliases.
   always_comb begin
      accept  = RAM_WEN && rdy_q;
      hit_ram = (RAM_AD_IN < ADDR_W'(RAM_WORDS));
      hit_io  = (RAM_AD_IN == IO_OUT_ADDR);
   end

   // Storage, handshake and error flags. Writes only land in IDLE and the
   // clear only runs in CLEAR, so the two never target the array together.
   always_ff @(posedge CLK_WB) begin
      if (RST) begin
         // NOTE: the array is plain flops, so it can be reset; software expects zeros after reset.
         for (int i = 0; i < RAM_WORDS; i++) mem_q[i] <= '0;
         io_q  <= '0;
         cnt_q <= '0;
         rdy_q <= 1'b1;
         err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every flop samples pre-edge values.
         rdy_q <= (state_d == IDLE);
         err_q <= accept && !hit_ram && !hit_io;
         if (accept && hit_ram) mem_q[RAM_AD_IN[CNT_W-1:0]] <= RAM_DATA_IN;
         if (accept && hit_io)  io_q <= RAM_DATA_IN;
         if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
            cnt_q        <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign RAM_RDY  = rdy_q;
   assign WR_ERR   = err_q;
   assign IO64_OUT = io_q;
   assign RAM_0    = mem_q[0];
   assign RAM_1    = mem_q[1];
   assign RAM_2    = mem_q[2];
   assign RAM_3    = mem_q[3];
   assign RAM_4    = mem_q[4];
   assign RAM_5    = mem_q[5];
   assign RAM_6    = mem_q[6];
   assign RAM_7    = mem_q[7];

endmodule

// File: tb/tb_ram_wb.sv
// Directed bench for ram_wb: reset, mapped/unmapped writes, clear timing,
// writes held across a clear, reset during a clear, and clear-vs-write overlap.
module tb_ram_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ad;
   logic [15:0] din;
   logic        wen;
   logic        clr_req;
   logic        rdy;
   logic        err;
   logic [15:0] ram [8];
   logic [15:0] io_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_wb dut (
      .CLK_WB      (clk),
      .RST         (rst),
      .RAM_AD_IN   (ad),
      .RAM_DATA_IN (din),
      .RAM_WEN     (wen),
      .CLR_REQ     (clr_req),
      .RAM_RDY     (rdy),
      .WR_ERR      (err),
      .RAM_0       (ram[0]),
      .RAM_1       (ram[1]),
      .RAM_2       (ram[2]),
      .RAM_3       (ram[3]),
      .RAM_4       (ram[4]),
      .RAM_5       (ram[5]),
      .RAM_6       (ram[6]),
      .RAM_7       (ram[7]),
      .IO64_OUT    (io_out)
   );

   // One clock edge; outputs are then sampled and inputs changed 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_req(input logic [7:0] a, input logic [15:0] d);
      wen = 1'b1;
      ad  = a;
      din = d;
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; clr_req = 1'b0; ad = '0; din = '0;

      // Reset state.
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) check($sformatf("reset_ram%0d", i), ram[i], 16'h0000);
      check("reset_io", io_out, 16'h0000);
      check("reset_rdy", {15'b0, rdy}, 16'h0001);
      check("reset_err", {15'b0, err}, 16'h0000);
      step();
      check("idle_rdy", {15'b0, rdy}, 16'h0001);

      // Back-to-back mapped writes.
      write_req(8'h03, 16'hBEEF);
      step();
      check("wr3_data", ram[3], 16'hBEEF);
      check("wr3_err", {15'b0, err}, 16'h0000);
      write_req(8'h40, 16'h1234);
      step();
      wen = 1'b0;
      check("wr40_io", io_out, 16'h1234);
      check("wr40_ram2", ram[2], 16'h0000);
      check("wr40_ram4", ram[4], 16'h0000);
      check("wr40_ram0", ram[0], 16'h0000);

      // Unmapped writes: 0x41 is input-only, 0x08 is just past the RAM.
      write_req(8'h41, 16'hFFFF);
      step();
      check("wr41_err", {15'b0, err}, 16'h0001);
      check("wr41_io", io_out, 16'h1234);
      write_req(8'h08, 16'h0001);
      step();
      wen = 1'b0;
      check("wr08_err", {15'b0, err}, 16'h0001);
      check("wr08_ram0", ram[0], 16'h0000);
      check("wr08_ram3", ram[3], 16'hBEEF);
      check("wr08_io", io_out, 16'h1234);
      step();
      check("err_drop", {15'b0, err}, 16'h0000);

      // Fill all words, set the port, then clear with a write held throughout.
      for (int n = 0; n < 8; n++) begin
         write_req(8'(n), 16'h00A0 + 16'(n));
         step();
      end
      write_req(8'h40, 16'h5555);
      step();
      wen = 1'b0;
      for (int n = 0; n < 8; n++) check($sformatf("fill_ram%0d", n), ram[n], 16'h00A0 + 16'(n));
      clr_req = 1'b1;
      step();  // E0
      clr_req = 1'b0;
      check("clr_e0_rdy", {15'b0, rdy}, 16'h0000);
      check("clr_e0_ram0", ram[0], 16'h00A0);
      write_req(8'h02, 16'h7777);
      for (int k = 0; k < 8; k++) begin
         step();  // E(k+1)
         check($sformatf("clr_word%0d", k), ram[k], 16'h0000);
         check($sformatf("clr_rdy_e%0d", k + 1), {15'b0, rdy}, (k == 7) ? 16'h0001 : 16'h0000);
         check($sformatf("clr_io_e%0d", k + 1), io_out, 16'h5555);
         if (k < 7) check($sformatf("clr_keep%0d", k + 1), ram[k + 1], 16'h00A0 + 16'(k + 1));
      end
      check("held_not_taken", ram[2], 16'h0000);
      step();  // held write accepted here
      wen = 1'b0;
      check("held_taken", ram[2], 16'h7777);
      check("held_err", {15'b0, err}, 16'h0000);
      step();
      check("held_stays", ram[2], 16'h7777);

      // Reset at clear cycle 4, with competing request and write on that edge.
      write_req(8'h06, 16'h6666);
      step();
      wen = 1'b0;
      check("pre_rst_ram6", ram[6], 16'h6666);
      clr_req = 1'b1;
      step();  // E0
      clr_req = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      clr_req = 1'b1;
      write_req(8'h01, 16'hAAAA);
      step();
      rst = 1'b0;
      clr_req = 1'b0;
      wen = 1'b0;
      for (int i = 0; i < 8; i++) check($sformatf("rst_clr_ram%0d", i), ram[i], 16'h0000);
      check("rst_clr_io", io_out, 16'h0000);
      check("rst_clr_rdy", {15'b0, rdy}, 16'h0001);
      check("rst_clr_err", {15'b0, err}, 16'h0000);
      step();
      check("rst_clr_idle", {15'b0, rdy}, 16'h0001);

      // Same-edge clear request and write: write lands, then gets cleared.
      clr_req = 1'b1;
      write_req(8'h05, 16'h1111);
      step();  // E0
      clr_req = 1'b0;
      wen = 1'b0;
      check("ovl_write", ram[5], 16'h1111);
      check("ovl_rdy", {15'b0, rdy}, 16'h0000);
      for (int k = 0; k < 8; k++) step();
      check("ovl_ram5", ram[5], 16'h0000);
      check("ovl_rdy_back", {15'b0, rdy}, 16'h0001);

      // Unmapped write right after the clear still flags.
      write_req(8'hFF, 16'h0F0F);
      step();
      wen = 1'b0;
      check("wrff_err", {15'b0, err}, 16'h0001);
      step();
      check("wrff_err_drop", {15'b0, err}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
